// File: rtl/bakraid_pkg.sv
// Shared types and constants for the Bakraid PCM fetch arbiter.
package bakraid_pkg;

    localparam int unsigned NPORTS     = 3;
    localparam int unsigned PCM_AW     = 22;
    localparam int unsigned TAG_W      = PCM_AW - 1;
    localparam logic [1:0]  GRANT_IDLE = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } arb_state_t;

    // Port index reached by stepping k places round-robin from prio.
    function automatic logic [1:0] rr_index(input logic [1:0] prio, input int unsigned k);
        logic [2:0] s;
        s = {1'b0, prio} + 3'(k);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Successor of a port in round-robin order.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/bakraid_pcm_cache_line.sv
// One-word read cache for a single PCM fetch port: hit compare and byte select.
module bakraid_pcm_cache_line
    import bakraid_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cs,
    input  logic [PCM_AW-1:0] i_addr,
    input  logic              i_fill,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic [15:0]       i_fill_word,
    input  logic              i_inval,
    output logic              o_hit,
    output logic [7:0]        o_dout
);

    logic             r_valid;
    logic [TAG_W-1:0] r_tag;
    logic [15:0]      r_word;

    // Line state: invalidate wins over a same-cycle fill so ROM loads never cache stale data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_word  <= '0;
        end else begin
            if (i_inval) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= 1'b1;
            end
            if (i_fill) begin
                r_tag  <= i_fill_tag;
                r_word <= i_fill_word;
            end
        end
    end

    // Hit and byte select, purely combinational from the stored line.
    always_comb begin
        o_hit  = i_cs && r_valid && (r_tag == i_addr[PCM_AW-1:1]);
        o_dout = i_addr[0] ? r_word[15:8] : r_word[7:0];
    end

endmodule

// File: rtl/bakraid_pcm_arbiter.sv
// Shares one SDRAM read slot between the three YMZ280B PCM fetch ports.
module bakraid_pcm_arbiter
    import bakraid_pkg::*;
#(
    parameter logic [PCM_AW-1:0] BASE = 22'h000000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              DOWNLOADING,

    input  logic              PCM_CS,
    input  logic [PCM_AW-1:0] PCM_ADDR,
    output logic [7:0]        PCM_DOUT,
    output logic              PCM_OK,

    input  logic              PCM1_CS,
    input  logic [PCM_AW-1:0] PCM1_ADDR,
    output logic [7:0]        PCM1_DOUT,
    output logic              PCM1_OK,

    input  logic              PCM2_CS,
    input  logic [PCM_AW-1:0] PCM2_ADDR,
    output logic [7:0]        PCM2_DOUT,
    output logic              PCM2_OK,

    output logic [PCM_AW-1:0] MEM_ADDR,
    output logic              MEM_RD,
    input  logic              MEM_ACK,
    input  logic              MEM_RDY,
    input  logic [15:0]       MEM_DATA,

    output logic [1:0]        GRANT
);

    arb_state_t        r_state;
    logic [1:0]        r_g;
    logic [TAG_W-1:0]  r_tag_l;
    logic [PCM_AW-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [1:0]        r_prio;

    arb_state_t        w_state_nxt;
    logic [1:0]        w_g_nxt;
    logic [TAG_W-1:0]  w_tag_l_nxt;
    logic [PCM_AW-1:0] w_mem_addr_nxt;
    logic              w_mem_rd_nxt;
    logic [1:0]        w_prio_nxt;
    logic              w_fill;

    logic [NPORTS-1:0] w_cs;
    logic [PCM_AW-1:0] w_addr [NPORTS];
    logic [7:0]        w_dout [NPORTS];
    logic [NPORTS-1:0] w_hit;
    logic [NPORTS-1:0] w_miss;

    logic              w_pick_found;
    logic [1:0]        w_pick;
    logic [TAG_W-1:0]  w_pick_tag;

    // Gather the three ports into arrays so the caches can be generated.
    always_comb begin
        w_cs      = {PCM2_CS, PCM1_CS, PCM_CS};
        w_addr[0] = PCM_ADDR;
        w_addr[1] = PCM1_ADDR;
        w_addr[2] = PCM2_ADDR;
    end

    for (genvar i = 0; i < NPORTS; i++) begin : g_line
        bakraid_pcm_cache_line u_line (
            .i_clk       (CLK),
            .i_rst       (RESET),
            .i_cs        (w_cs[i]),
            .i_addr      (w_addr[i]),
            .i_fill      (w_fill && (r_g == 2'(i))),
            .i_fill_tag  (r_tag_l),
            .i_fill_word (MEM_DATA),
            .i_inval     (DOWNLOADING),
            .o_hit       (w_hit[i]),
            .o_dout      (w_dout[i])
        );
    end

    // Round-robin pick of the first missing port starting at prio.
    always_comb begin
        w_miss       = w_cs & ~w_hit;
        w_pick_found = 1'b0;
        w_pick       = 2'd0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (!w_pick_found && w_miss[rr_index(r_prio, k)]) begin
                w_pick_found = 1'b1;
                w_pick       = rr_index(r_prio, k);
            end
        end
        case (w_pick)
            2'd1:    w_pick_tag = w_addr[1][PCM_AW-1:1];
            2'd2:    w_pick_tag = w_addr[2][PCM_AW-1:1];
            default: w_pick_tag = w_addr[0][PCM_AW-1:1];
        endcase
    end

    // Next-state logic for the single-outstanding-request FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_g_nxt        = r_g;
        w_tag_l_nxt    = r_tag_l;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_rd_nxt   = r_mem_rd;
        w_prio_nxt     = r_prio;
        w_fill         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!DOWNLOADING && w_pick_found) begin
                    w_g_nxt        = w_pick;
                    w_tag_l_nxt    = w_pick_tag;
                    w_mem_addr_nxt = BASE + {1'b0, w_pick_tag};
                    w_mem_rd_nxt   = 1'b1;
                    w_state_nxt    = StIssue;
                end
            end
            StIssue: begin
                if (MEM_ACK) begin
                    w_mem_rd_nxt = 1'b0;
                    // Data may come back in the accept cycle; complete without visiting WAIT.
                    if (MEM_RDY) begin
                        w_fill      = 1'b1;
                        w_prio_nxt  = next_port(r_g);
                        w_state_nxt = StIdle;
                    end else begin
                        w_state_nxt = StWait;
                    end
                end
            end
            StWait: begin
                if (MEM_RDY) begin
                    w_fill      = 1'b1;
                    w_prio_nxt  = next_port(r_g);
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_mem_rd_nxt = 1'b0;
                w_state_nxt  = StIdle;
            end
        endcase
    end

    // FSM and request registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= StIdle;
            r_g        <= 2'd0;
            r_tag_l    <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_prio     <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_g        <= w_g_nxt;
            r_tag_l    <= w_tag_l_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_prio     <= w_prio_nxt;
        end
    end

    // Output mapping.
    always_comb begin
        MEM_ADDR  = r_mem_addr;
        MEM_RD    = r_mem_rd;
        GRANT     = (r_state == StIdle) ? GRANT_IDLE : r_g;
        PCM_DOUT  = w_dout[0];
        PCM1_DOUT = w_dout[1];
        PCM2_DOUT = w_dout[2];
        PCM_OK    = w_hit[0];
        PCM1_OK   = w_hit[1];
        PCM2_OK   = w_hit[2];
    end

endmodule

// File: tb/tb_bakraid_pcm_arbiter.sv
// Directed bench for bakraid_pcm_arbiter with hand-computed expectations (BASE = 22'h100000).
module tb_bakraid_pcm_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        DOWNLOADING;
    logic        PCM_CS, PCM1_CS, PCM2_CS;
    logic [21:0] PCM_ADDR, PCM1_ADDR, PCM2_ADDR;
    logic [7:0]  PCM_DOUT, PCM1_DOUT, PCM2_DOUT;
    logic        PCM_OK, PCM1_OK, PCM2_OK;
    logic [21:0] MEM_ADDR;
    logic        MEM_RD;
    logic        MEM_ACK, MEM_RDY;
    logic [15:0] MEM_DATA;
    logic [1:0]  GRANT;

    int n_total = 0;
    int n_bad   = 0;

    bakraid_pcm_arbiter #(
        .BASE (22'h100000)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .DOWNLOADING (DOWNLOADING),
        .PCM_CS      (PCM_CS),
        .PCM_ADDR    (PCM_ADDR),
        .PCM_DOUT    (PCM_DOUT),
        .PCM_OK      (PCM_OK),
        .PCM1_CS     (PCM1_CS),
        .PCM1_ADDR   (PCM1_ADDR),
        .PCM1_DOUT   (PCM1_DOUT),
        .PCM1_OK     (PCM1_OK),
        .PCM2_CS     (PCM2_CS),
        .PCM2_ADDR   (PCM2_ADDR),
        .PCM2_DOUT   (PCM2_DOUT),
        .PCM2_OK     (PCM2_OK),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_RD      (MEM_RD),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDY     (MEM_RDY),
        .MEM_DATA    (MEM_DATA),
        .GRANT       (GRANT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Wait (bounded) for a request, check it, then ACK and RDY on separate cycles.
    task automatic do_txn(input string tag, input logic [1:0] exp_g, input logic [21:0] exp_addr,
                          input logic [15:0] data);
        int n;
        n = 0;
        while (!MEM_RD && n < 8) begin
            step();
            n++;
        end
        chk({tag, "_rd"}, 32'(MEM_RD), 32'd1);
        chk({tag, "_grant"}, 32'(GRANT), 32'(exp_g));
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'(exp_addr));
        MEM_ACK = 1'b1;
        step();
        MEM_ACK  = 1'b0;
        MEM_RDY  = 1'b1;
        MEM_DATA = data;
        step();
        MEM_RDY = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; DOWNLOADING = 1'b0;
        PCM_CS = 1'b0; PCM1_CS = 1'b0; PCM2_CS = 1'b0;
        PCM_ADDR = '0; PCM1_ADDR = '0; PCM2_ADDR = '0;
        MEM_ACK = 1'b0; MEM_RDY = 1'b0; MEM_DATA = '0;
        step(); step();
        RESET = 1'b0;
        step();

        // Reset state.
        chk("rst_ok", 32'({PCM_OK, PCM1_OK, PCM2_OK}), 32'd0);
        chk("rst_dout0", 32'(PCM_DOUT), 32'd0);
        chk("rst_grant", 32'(GRANT), 32'd3);
        chk("rst_rd", 32'(MEM_RD), 32'd0);
        chk("rst_addr", 32'(MEM_ADDR), 32'd0);

        // Single miss, fill, then byte hit in the same word.
        PCM_CS = 1'b1; PCM_ADDR = 22'h000100;
        #1;
        chk("t1_rd_same_cycle", 32'(MEM_RD), 32'd0);
        step();
        chk("t1_rd", 32'(MEM_RD), 32'd1);
        chk("t1_addr", 32'(MEM_ADDR), 32'h100080);
        chk("t1_grant", 32'(GRANT), 32'd0);
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        chk("t1_rd_drop", 32'(MEM_RD), 32'd0);
        MEM_RDY = 1'b1; MEM_DATA = 16'hBEEF;
        #1;
        chk("t1_ok_before", 32'(PCM_OK), 32'd0);
        step();
        MEM_RDY = 1'b0;
        chk("t1_ok", 32'(PCM_OK), 32'd1);
        chk("t1_dout_lo", 32'(PCM_DOUT), 32'hEF);
        chk("t1_grant_idle", 32'(GRANT), 32'd3);
        PCM_ADDR = 22'h000101;
        #1;
        chk("t1_dout_hi", 32'(PCM_DOUT), 32'hBE);
        chk("t1_ok_hi", 32'(PCM_OK), 32'd1);
        step();
        chk("t1_no_rd", 32'(MEM_RD), 32'd0);

        // Three simultaneous misses from prio=0, twice; then port 1 alone.
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        PCM_CS = 1'b1; PCM1_CS = 1'b1; PCM2_CS = 1'b1;
        PCM_ADDR = 22'h000400; PCM1_ADDR = 22'h000200; PCM2_ADDR = 22'h000300;
        do_txn("t2a0", 2'd0, 22'h100200, 16'h1111);
        do_txn("t2a1", 2'd1, 22'h100100, 16'h2222);
        do_txn("t2a2", 2'd2, 22'h100180, 16'h3333);
        chk("t2a_ok", 32'({PCM_OK, PCM1_OK, PCM2_OK}), 32'b111);
        chk("t2a_dout1", 32'(PCM1_DOUT), 32'h22);
        PCM_ADDR = 22'h000402; PCM1_ADDR = 22'h000202; PCM2_ADDR = 22'h000302;
        do_txn("t2b0", 2'd0, 22'h100201, 16'hA0A1);
        do_txn("t2b1", 2'd1, 22'h100101, 16'hB0B1);
        do_txn("t2b2", 2'd2, 22'h100181, 16'hC0C1);
        PCM1_ADDR = 22'h000204;
        do_txn("t2c", 2'd1, 22'h100102, 16'h4444);
        PCM1_ADDR = 22'h000206;
        step();
        chk("t2d_rd_immediate", 32'(MEM_RD), 32'd1);
        chk("t2d_grant", 32'(GRANT), 32'd1);
        do_txn("t2d", 2'd1, 22'h100103, 16'h5555);

        // Address change while in WAIT: fill uses latched tag, port misses again.
        PCM_CS = 1'b0; PCM2_CS = 1'b0;
        PCM1_ADDR = 22'h000010;
        step();
        chk("t3_rd", 32'(MEM_RD), 32'd1);
        chk("t3_addr", 32'(MEM_ADDR), 32'h100008);
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        PCM1_ADDR = 22'h000020;
        MEM_RDY = 1'b1; MEM_DATA = 16'h5566;
        step();
        MEM_RDY = 1'b0;
        chk("t3_ok_stale", 32'(PCM1_OK), 32'd0);
        step();
        chk("t3_rd2", 32'(MEM_RD), 32'd1);
        chk("t3_addr2", 32'(MEM_ADDR), 32'h100010);
        do_txn("t3b", 2'd1, 22'h100010, 16'h7788);
        chk("t3_ok", 32'(PCM1_OK), 32'd1);
        chk("t3_dout", 32'(PCM1_DOUT), 32'h88);

        // All ports hit cached words; DOWNLOADING invalidates and blocks issue.
        PCM_CS = 1'b1; PCM2_CS = 1'b1;
        #1;
        chk("t4_ok_all", 32'({PCM_OK, PCM1_OK, PCM2_OK}), 32'b111);
        chk("t4_dout0", 32'(PCM_DOUT), 32'hA1);
        DOWNLOADING = 1'b1;
        step();
        chk("t4_ok_drop", 32'({PCM_OK, PCM1_OK, PCM2_OK}), 32'b000);
        chk("t4_no_rd_a", 32'(MEM_RD), 32'd0);
        step();
        chk("t4_no_rd_b", 32'(MEM_RD), 32'd0);
        chk("t4_grant_idle", 32'(GRANT), 32'd3);
        DOWNLOADING = 1'b0;
        step();
        chk("t4_rd", 32'(MEM_RD), 32'd1);
        chk("t4_grant", 32'(GRANT), 32'd2);
        chk("t4_addr", 32'(MEM_ADDR), 32'h100181);
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        DOWNLOADING = 1'b1;
        MEM_RDY = 1'b1; MEM_DATA = 16'hDEAD;
        step();
        MEM_RDY = 1'b0;
        chk("t4_inflight_ok", 32'(PCM2_OK), 32'd0);
        step();
        chk("t4_no_rd_c", 32'(MEM_RD), 32'd0);
        DOWNLOADING = 1'b0;

        // Reset asserted while in WAIT; stray RDY afterwards is ignored.
        do_txn("t5a", 2'd0, 22'h100201, 16'h0F0E);
        do_txn("t5b", 2'd1, 22'h100010, 16'h1A1B);
        step();
        chk("t5c_rd", 32'(MEM_RD), 32'd1);
        chk("t5c_grant", 32'(GRANT), 32'd2);
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
        chk("t5_ok_pre", 32'({PCM_OK, PCM1_OK}), 32'b11);
        chk("t5_grant_wait", 32'(GRANT), 32'd2);
        RESET = 1'b1;
        #1;
        chk("t5_rst_rd", 32'(MEM_RD), 32'd0);
        chk("t5_rst_grant", 32'(GRANT), 32'd3);
        chk("t5_rst_ok", 32'({PCM_OK, PCM1_OK, PCM2_OK}), 32'b000);
        PCM_CS = 1'b0; PCM1_CS = 1'b0; PCM2_CS = 1'b0;
        step();
        RESET = 1'b0;
        MEM_RDY = 1'b1; MEM_DATA = 16'hFFFF;
        step();
        MEM_RDY = 1'b0;
        chk("t5_stray_grant", 32'(GRANT), 32'd3);
        PCM_CS = 1'b1; PCM1_CS = 1'b1; PCM2_CS = 1'b1;
        #1;
        chk("t5_stray_ok", 32'({PCM_OK, PCM1_OK, PCM2_OK}), 32'b000);
        chk("t5_stray_dout0", 32'(PCM_DOUT), 32'h00);
        chk("t5_stray_dout2", 32'(PCM2_DOUT), 32'h00);

        // ACK and RDY in the same ISSUE cycle.
        step();
        chk("t6_rd", 32'(MEM_RD), 32'd1);
        chk("t6_grant", 32'(GRANT), 32'd0);
        MEM_ACK = 1'b1; MEM_RDY = 1'b1; MEM_DATA = 16'h1234;
        step();
        MEM_ACK = 1'b0; MEM_RDY = 1'b0;
        chk("t6_grant_idle", 32'(GRANT), 32'd3);
        chk("t6_rd_drop", 32'(MEM_RD), 32'd0);
        chk("t6_ok", 32'(PCM_OK), 32'd1);
        chk("t6_dout", 32'(PCM_DOUT), 32'h34);
        step();
        chk("t6_next_grant", 32'(GRANT), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
